// File: rtl/jtkcpu_pkg.sv
// Shared register codes and helpers for the jtkcpu stack push/pull engine.
package jtkcpu_pkg;

    typedef enum logic [2:0] {
        REG_CC = 3'd0,
        REG_A  = 3'd1,
        REG_B  = 3'd2,
        REG_DP = 3'd3,
        REG_X  = 3'd4,
        REG_Y  = 3'd5,
        REG_US = 3'd6,
        REG_PC = 3'd7
    } reg_code_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } pshpul_state_e;

    // X, Y, U/S and PC are the 16-bit registers and occupy two stack bytes.
    function automatic logic is16(input logic [2:0] code);
        return code >= 3'(REG_X);
    endfunction

endpackage

// File: rtl/jtkcpu_pshpul_pick.sv
// Priority picker: returns the next set postbyte bit, highest-first for push
// and lowest-first for pull.
module jtkcpu_pshpul_pick (
    input  logic [7:0] mask_i,
    input  logic       hi_first_i,
    output logic [2:0] idx_o
);

    // The last matching iteration wins, so the scan direction sets the priority.
    always_comb begin
        idx_o = 3'd0;
        if (hi_first_i) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_i[i]) idx_o = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (mask_i[i]) idx_o = 3'(i);
            end
        end
    end

endmodule

// File: rtl/jtkcpu_pshpul.sv
// Stack push/pull engine for PSHS/PSHU/PULS/PULU: walks the postbyte mask and
// issues one byte bus cycle per active cen cycle.
module jtkcpu_pshpul
    import jtkcpu_pkg::*;
(
    input  logic        rst,
    input  logic        clk,
    input  logic        cen,
    input  logic        psh_go,
    input  logic        pul_go,
    input  logic [7:0]  postbyte,
    input  logic [15:0] sp_in,
    input  logic [7:0]  rdata,
    input  logic [7:0]  din,
    output logic        busy,
    output logic        done,
    output logic [15:0] addr,
    output logic [7:0]  dout,
    output logic        we,
    output logic        re,
    output logic [2:0]  rsel,
    output logic        rhi,
    output logic        ld_we,
    output logic [2:0]  ld_sel,
    output logic        ld_hi,
    output logic [7:0]  ld_data,
    output logic [15:0] sp_out,
    output logic        sp_we
);

    pshpul_state_e state_q, state_d;
    logic [7:0]    mask_q, mask_d;
    logic          push_q, push_d;
    logic [15:0]   sp_q, sp_d;
    logic          half_q, half_d;
    logic          done_q, done_d;
    logic [15:0]   sp_out_q, sp_out_d;
    logic          ld_we_q, ld_we_d;
    logic [2:0]    ld_sel_q, ld_sel_d;
    logic          ld_hi_q, ld_hi_d;
    logic [7:0]    ld_data_q, ld_data_d;

    logic [2:0]    cur_idx;
    logic          cur_wide;
    logic          cur_hi;
    logic [15:0]   cur_addr;
    logic [15:0]   sp_next;
    logic [7:0]    mask_left;

    jtkcpu_pshpul_pick u_pick (
        .mask_i     (mask_q),
        .hi_first_i (push_q),
        .idx_o      (cur_idx)
    );

    // half_q marks the second byte of a 16-bit register: push stores low then
    // high, pull restores high then low.
    always_comb begin
        cur_wide  = is16(cur_idx);
        cur_hi    = cur_wide & (push_q ? half_q : ~half_q);
        cur_addr  = push_q ? sp_q - 16'd1 : sp_q;
        sp_next   = push_q ? sp_q - 16'd1 : sp_q + 16'd1;
        mask_left = (cur_wide && !half_q) ? mask_q : (mask_q & ~(8'd1 << cur_idx));
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path
        // through this block can infer a latch.
        state_d   = state_q;
        mask_d    = mask_q;
        push_d    = push_q;
        sp_d      = sp_q;
        half_d    = half_q;
        done_d    = done_q;
        sp_out_d  = sp_out_q;
        ld_we_d   = ld_we_q;
        ld_sel_d  = ld_sel_q;
        ld_hi_d   = ld_hi_q;
        ld_data_d = ld_data_q;

        if (cen) begin
            done_d  = 1'b0;
            ld_we_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (psh_go || pul_go) begin
                        if (postbyte != 8'd0) begin
                            state_d = ST_XFER;
                            mask_d  = postbyte;
                            push_d  = psh_go;
                            sp_d    = sp_in;
                            half_d  = 1'b0;
                        end else begin
                            done_d   = 1'b1;
                            sp_out_d = sp_in;
                        end
                    end
                end
                ST_XFER: begin
                    sp_d   = sp_next;
                    mask_d = mask_left;
                    half_d = cur_wide & ~half_q;
                    if (!push_q) begin
                        ld_we_d   = 1'b1;
                        ld_sel_d  = cur_idx;
                        ld_hi_d   = cur_hi;
                        ld_data_d = din;
                    end
                    if (mask_left == 8'd0) begin
                        state_d  = ST_IDLE;
                        done_d   = 1'b1;
                        sp_out_d = sp_next;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // its pre-edge inputs regardless of evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mask_q    <= 8'd0;
            push_q    <= 1'b0;
            sp_q      <= 16'd0;
            half_q    <= 1'b0;
            done_q    <= 1'b0;
            sp_out_q  <= 16'd0;
            ld_we_q   <= 1'b0;
            ld_sel_q  <= 3'd0;
            ld_hi_q   <= 1'b0;
            ld_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            push_q    <= push_d;
            sp_q      <= sp_d;
            half_q    <= half_d;
            done_q    <= done_d;
            sp_out_q  <= sp_out_d;
            ld_we_q   <= ld_we_d;
            ld_sel_q  <= ld_sel_d;
            ld_hi_q   <= ld_hi_d;
            ld_data_q <= ld_data_d;
        end
    end

    assign busy    = (state_q == ST_XFER);
    assign we      = busy & push_q;
    assign re      = busy & ~push_q;
    assign addr    = busy ? cur_addr : 16'd0;
    assign rsel    = busy ? cur_idx : 3'd0;
    assign rhi     = busy & cur_hi;
    assign dout    = we ? rdata : 8'd0;
    assign done    = done_q;
    assign sp_we   = done_q;
    assign sp_out  = sp_out_q;
    assign ld_we   = ld_we_q;
    assign ld_sel  = ld_sel_q;
    assign ld_hi   = ld_hi_q;
    assign ld_data = ld_data_q;

endmodule

// File: tb/tb_jtkcpu_pshpul.sv
// Self-checking bench for jtkcpu_pshpul: a transfer-list model built from the
// postbyte ordering rules, a hashed register file and a hashed read bus.
module tb_jtkcpu_pshpul;

    logic        rst, clk, cen, psh_go, pul_go;
    logic [7:0]  postbyte;
    logic [15:0] sp_in;
    logic [7:0]  rdata, din;
    logic        busy, done, we, re, rhi, ld_we, ld_hi, sp_we;
    logic [15:0] addr, sp_out;
    logic [7:0]  dout, ld_data;
    logic [2:0]  rsel, ld_sel;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rseed = 8'h11;
    logic [7:0] dseed = 8'h22;
    logic [7:0] mem [0:65535];

    typedef struct packed {
        logic [2:0]  code;
        logic        hi;
        logic [15:0] addr;
    } xfer_t;

    xfer_t exp_q[$];

    function automatic logic [7:0] reg_val(input logic [7:0] seed, input logic [2:0] code,
                                           input logic hi);
        return seed + (8'({code, hi}) * 8'd29) + 8'd3;
    endfunction

    function automatic logic [7:0] din_val(input logic [7:0] seed, input logic [15:0] a);
        return seed ^ a[7:0] ^ {a[14:8], a[15]};
    endfunction

    assign rdata = reg_val(rseed, rsel, rhi);
    assign din   = din_val(dseed, addr);

    jtkcpu_pshpul dut (
        .rst(rst), .clk(clk), .cen(cen), .psh_go(psh_go), .pul_go(pul_go),
        .postbyte(postbyte), .sp_in(sp_in), .rdata(rdata), .din(din),
        .busy(busy), .done(done), .addr(addr), .dout(dout), .we(we), .re(re),
        .rsel(rsel), .rhi(rhi), .ld_we(ld_we), .ld_sel(ld_sel), .ld_hi(ld_hi),
        .ld_data(ld_data), .sp_out(sp_out), .sp_we(sp_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bus memory: a write lands only on an enabled edge outside reset.
    always @(posedge clk) begin
        if (!rst && cen && we) mem[addr] = dout;
    end

    // Called at a negedge; presents a go strobe for exactly one enabled edge.
    task automatic issue_go(input logic p, input logic q, input logic [7:0] pb,
                            input logic [15:0] sp);
        psh_go   = p;
        pul_go   = q;
        postbyte = pb;
        sp_in    = sp;
        cen      = 1'b1;
        @(negedge clk);
        psh_go   = 1'b0;
        pul_go   = 1'b0;
        postbyte = 8'($urandom);
        sp_in    = 16'($urandom);
    endtask

    // Runs one PSH/PUL instruction and checks every cycle against the model.
    task automatic run_op(input logic p, input logic q, input logic [7:0] pb,
                          input logic [15:0] sp, input int cen_pct, input logic inject,
                          output logic [15:0] got_sp);
        logic [15:0] a;
        int          n, k, busy_dut, guard, want_cycles;
        logic        exp_ld, done_over;
        xfer_t       ld_ent;

        rseed = 8'($urandom);
        dseed = 8'($urandom);
        exp_q.delete();
        a = sp;
        if (p) begin
            for (int b = 7; b >= 0; b--) begin
                if (pb[b]) begin
                    a = a - 16'd1;
                    exp_q.push_back({3'(b), 1'b0, a});
                    if (b >= 4) begin
                        a = a - 16'd1;
                        exp_q.push_back({3'(b), 1'b1, a});
                    end
                end
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (pb[b]) begin
                    exp_q.push_back({3'(b), (b >= 4) ? 1'b1 : 1'b0, a});
                    a = a + 16'd1;
                    if (b >= 4) begin
                        exp_q.push_back({3'(b), 1'b0, a});
                        a = a + 16'd1;
                    end
                end
            end
        end
        n = exp_q.size();
        want_cycles = 2 * $countones(pb[7:4]) + $countones(pb[3:0]);

        issue_go(p, q, pb, sp);
        k = 0; busy_dut = 0; exp_ld = 1'b0; done_over = 1'b0; got_sp = 16'd0; ld_ent = '0;
        for (guard = 0; guard < 400 && !done_over; guard++) begin
            checks++;
            if (busy !== (k < n)) begin
                failures++;
                $display("FAIL busy op=%02h byte=%0d got=%b exp=%b", pb, k, busy, (k < n));
            end
            checks++;
            if (done !== (k == n) || sp_we !== (k == n)) begin
                failures++;
                $display("FAIL done_sp_we op=%02h byte=%0d got=%b/%b exp=%b", pb, k, done, sp_we, (k == n));
            end
            checks++;
            if (we === 1'b1 && re === 1'b1) begin
                failures++;
                $display("FAIL we_re_both op=%02h byte=%0d got=11 exp=not both", pb, k);
            end
            if (k < n) begin
                checks++;
                if (addr !== exp_q[k].addr || we !== p || re !== !p) begin
                    failures++;
                    $display("FAIL bus_cycle op=%02h byte=%0d got addr=%04h we=%b re=%b exp addr=%04h we=%b re=%b",
                             pb, k, addr, we, re, exp_q[k].addr, p, !p);
                end
                checks++;
                if (rsel !== exp_q[k].code || rhi !== exp_q[k].hi) begin
                    failures++;
                    $display("FAIL rsel op=%02h byte=%0d got=%0d/%b exp=%0d/%b",
                             pb, k, rsel, rhi, exp_q[k].code, exp_q[k].hi);
                end
                if (p) begin
                    checks++;
                    if (dout !== reg_val(rseed, exp_q[k].code, exp_q[k].hi)) begin
                        failures++;
                        $display("FAIL dout op=%02h byte=%0d got=%02h exp=%02h", pb, k, dout,
                                 reg_val(rseed, exp_q[k].code, exp_q[k].hi));
                    end
                end
            end else begin
                checks++;
                if (sp_out !== a) begin
                    failures++;
                    $display("FAIL sp_out op=%02h got=%04h exp=%04h", pb, sp_out, a);
                end
                got_sp = sp_out;
            end
            checks++;
            if (ld_we !== exp_ld) begin
                failures++;
                $display("FAIL ld_we op=%02h byte=%0d got=%b exp=%b", pb, k, ld_we, exp_ld);
            end
            if (exp_ld) begin
                checks++;
                if (ld_sel !== ld_ent.code || ld_hi !== ld_ent.hi ||
                    ld_data !== din_val(dseed, ld_ent.addr)) begin
                    failures++;
                    $display("FAIL ld_data op=%02h byte=%0d got=%0d/%b/%02h exp=%0d/%b/%02h", pb, k,
                             ld_sel, ld_hi, ld_data, ld_ent.code, ld_ent.hi, din_val(dseed, ld_ent.addr));
                end
            end

            psh_go = inject && guard == 0 && n > 0;
            pul_go = inject && guard == 0 && n > 0 && ($urandom_range(1) == 1);
            if (psh_go) postbyte = 8'($urandom);
            cen = ($urandom_range(99) < cen_pct);
            if (cen) begin
                if (busy === 1'b1) busy_dut++;
                if (k < n) begin
                    exp_ld = !p;
                    ld_ent = exp_q[k];
                    k++;
                end else begin
                    exp_ld    = 1'b0;
                    done_over = 1'b1;
                end
            end
            @(negedge clk);
        end
        psh_go = 1'b0;
        pul_go = 1'b0;
        cen    = 1'b1;

        checks++;
        if (!done_over) begin
            failures++;
            $display("FAIL timeout op=%02h got bytes=%0d exp=%0d", pb, k, n);
        end
        checks++;
        if (busy_dut != want_cycles) begin
            failures++;
            $display("FAIL busy_cycles op=%02h got=%0d exp=%0d", pb, busy_dut, want_cycles);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || ld_we !== 1'b0) begin
            failures++;
            $display("FAIL idle_after op=%02h got busy=%b done=%b ld_we=%b exp=000", pb, busy, done, ld_we);
        end
        if (p) begin
            foreach (exp_q[i]) begin
                checks++;
                if (mem[exp_q[i].addr] !== reg_val(rseed, exp_q[i].code, exp_q[i].hi)) begin
                    failures++;
                    $display("FAIL mem op=%02h addr=%04h got=%02h exp=%02h", pb, exp_q[i].addr,
                             mem[exp_q[i].addr], reg_val(rseed, exp_q[i].code, exp_q[i].hi));
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b0; psh_go = 1'b0; pul_go = 1'b0;
        postbyte = 8'h00; sp_in = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, we, re, ld_we, sp_we} !== 6'b0) begin
            failures++;
            $display("FAIL reset_strobes got=%b exp=000000", {busy, done, we, re, ld_we, sp_we});
        end
        checks++;
        if (addr !== 16'd0 || sp_out !== 16'd0) begin
            failures++;
            $display("FAIL reset_addr got=%04h/%04h exp=0000/0000", addr, sp_out);
        end
        checks++;
        if (ld_data !== 8'd0 || {rsel, ld_sel, rhi, ld_hi} !== 8'd0) begin
            failures++;
            $display("FAIL reset_sel got=%02h/%02h exp=00/00", ld_data, {rsel, ld_sel, rhi, ld_hi});
        end
        rst = 1'b0;
        cen = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_push_directed();
        logic [15:0] got;
        run_op(1'b1, 1'b0, 8'h86, 16'h1000, 100, 1'b0, got);
        checks++;
        if (got !== 16'h0FFC || mem[16'h0FFF] !== reg_val(rseed, 3'd7, 1'b0) ||
            mem[16'h0FFC] !== reg_val(rseed, 3'd1, 1'b0)) begin
            failures++;
            $display("FAIL push_86 got sp=%04h pcl=%02h a=%02h exp sp=0FFC pcl=%02h a=%02h", got,
                     mem[16'h0FFF], mem[16'h0FFC], reg_val(rseed, 3'd7, 1'b0), reg_val(rseed, 3'd1, 1'b0));
        end
    endtask

    task automatic test_pull_all();
        logic [15:0] got;
        run_op(1'b0, 1'b1, 8'hFF, 16'h0FF4, 100, 1'b0, got);
        checks++;
        if (got !== 16'h1000) begin
            failures++;
            $display("FAIL pull_ff got=%04h exp=1000", got);
        end
    endtask

    task automatic test_empty_mask();
        logic [15:0] got;
        run_op(1'b1, 1'b0, 8'h00, 16'h2000, 70, 1'b0, got);
        checks++;
        if (got !== 16'h2000) begin
            failures++;
            $display("FAIL empty_mask got=%04h exp=2000", got);
        end
    endtask

    task automatic test_wrap();
        logic [15:0] got;
        run_op(1'b1, 1'b0, 8'h02, 16'h0000, 100, 1'b0, got);
        checks++;
        if (got !== 16'hFFFF || mem[16'hFFFF] !== reg_val(rseed, 3'd1, 1'b0)) begin
            failures++;
            $display("FAIL wrap_push got sp=%04h byte=%02h exp sp=FFFF byte=%02h", got,
                     mem[16'hFFFF], reg_val(rseed, 3'd1, 1'b0));
        end
        run_op(1'b0, 1'b1, 8'h01, 16'hFFFF, 100, 1'b0, got);
        checks++;
        if (got !== 16'h0000) begin
            failures++;
            $display("FAIL wrap_pull got=%04h exp=0000", got);
        end
    endtask

    task automatic test_stall_priority();
        logic [15:0] got;
        run_op(1'b1, 1'b0, 8'h30, 16'h8000, 50, 1'b0, got);
        run_op(1'b1, 1'b1, 8'hC5, 16'h3000, 100, 1'b0, got);
        checks++;
        if (got !== 16'h2FFA) begin
            failures++;
            $display("FAIL both_go got=%04h exp=2FFA", got);
        end
        run_op(1'b1, 1'b0, 8'h5A, 16'h5000, 80, 1'b1, got);
        run_op(1'b0, 1'b1, 8'hA5, 16'h6000, 80, 1'b1, got);
    endtask

    task automatic test_reset_mid();
        logic [15:0] got;
        logic [7:0]  pcl, pch;
        rseed = 8'($urandom);
        pcl = reg_val(rseed, 3'd7, 1'b0);
        pch = reg_val(rseed, 3'd7, 1'b1);
        issue_go(1'b1, 1'b0, 8'hF0, 16'h4000);
        cen = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, we, done, sp_we} !== 4'b0) begin
            failures++;
            $display("FAIL reset_mid got busy/we/done/sp_we=%b exp=0000", {busy, we, done, sp_we});
        end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, sp_we} !== 3'b0) begin
                failures++;
                $display("FAIL reset_mid_quiet cyc=%0d got=%b exp=000", i, {busy, done, sp_we});
            end
        end
        checks++;
        if (mem[16'h3FFF] !== pcl || mem[16'h3FFE] !== pch) begin
            failures++;
            $display("FAIL reset_mid_mem got=%02h/%02h exp=%02h/%02h", mem[16'h3FFF], mem[16'h3FFE], pcl, pch);
        end
        run_op(1'b1, 1'b0, 8'hF0, 16'h4000, 100, 1'b0, got);
        checks++;
        if (got !== 16'h3FF8) begin
            failures++;
            $display("FAIL reset_mid_resume got=%04h exp=3FF8", got);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] got;
        logic        p, q;
        for (int i = 0; i < 25; i++) begin
            p = 1'($urandom_range(1));
            q = p ? 1'($urandom_range(1)) : 1'b1;
            run_op(p, q, 8'($urandom), 16'($urandom), $urandom_range(100, 40),
                   1'($urandom_range(1)), got);
        end
    endtask

    initial begin
        test_reset();
        test_push_directed();
        test_pull_all();
        test_empty_mask();
        test_wrap();
        test_stall_priority();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtkcpu_pshpul.md
Name: jtkcpu_pshpul

Overview:
- Stack push/pull engine. It consumes the psh_go/pul_go strobes issued by the microcode sequencer and executes PSHS/PSHU/PULS/PULU.
- It walks the postbyte register mask and generates one byte bus cycle per active cen cycle.
- It drives register-file read/load selects and returns the final stack pointer.
- The sequencer holds its routine on busy and resumes on done.

Parameters:
- None. Address is fixed at 16 bits, data at 8 bits.

Ports:
- rst  in  1  synchronous reset, active-high
- clk  in  1  single system clock
- cen  in  1  clock enable; all state advances only when cen=1
- psh_go  in  1  push request strobe from the ucode sequencer
- pul_go  in  1  pull request strobe from the ucode sequencer
- postbyte  in  8  register mask: b7 PC, b6 U/S, b5 Y, b4 X, b3 DP, b2 B, b1 A, b0 CC
- sp_in  in  16  current S or U value, latched on go
- rdata  in  8  register-file byte selected by rsel/rhi (combinational)
- din  in  8  bus read data
- busy  out  1  transfer in progress
- done  out  1  one-cen-cycle completion pulse
- addr  out  16  bus address
- dout  out  8  bus write data (=rdata during push cycles)
- we  out  1  bus write strobe
- re  out  1  bus read strobe
- rsel  out  3  register code (= postbyte bit index) for current byte
- rhi  out  1  1 = high byte of a 16-bit register
- ld_we  out  1  register load strobe (pull)
- ld_sel  out  3  register code being loaded
- ld_hi  out  1  high byte being loaded
- ld_data  out  8  byte to load
- sp_out  out  16  final stack pointer, valid when sp_we=1
- sp_we  out  1  stack pointer write, coincides with done

Behaviour:
- Interface clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE; busy, done, we, re, ld_we, sp_we = 0; addr, sp_out, ld_data = 0; rsel, ld_sel = 0; rhi, ld_hi = 0.
- States: IDLE, XFER.
- IDLE -> XFER: on a cen edge with (psh_go|pul_go) and postbyte != 0. Latch mask, direction and sp_in; busy=1 from the next cycle.
- Simultaneous psh_go and pul_go: push wins.
- postbyte == 0: stay IDLE. done=1 and sp_we=1 with sp_out=sp_in on the next cen cycle; no bus cycle.
- go while busy is ignored.
- Push order: b7 down to b0. Each 16-bit register (PC, U/S, Y, X) pushes low byte then high byte.
- Push addressing: pre-decrement, addr = sp-1, then sp = sp-1. we=1, dout=rdata.
- Pull order: b0 up to b7. Each 16-bit register pulls high byte then low byte.
- Pull addressing: post-increment, addr = sp, then sp = sp+1. re=1. din is sampled at the cen edge ending that cycle.
- Pull load timing: the sampled byte appears on ld_data with ld_sel/ld_hi and a one-cen-cycle ld_we on the following cycle.
- Throughput: exactly one byte per cen cycle.
- Total busy cycles = popcount(mask[7:4])*2 + popcount(mask[3:0]).
- Completion: at the cen edge ending the last byte, go to IDLE. done=1 and sp_we=1 for one cen cycle; busy=0 in that same cycle. For a pull, the final ld_we coincides with done.
- SP arithmetic is 16-bit modulo: a push from 0x0000 writes 0xFFFF; a pull from 0xFFFF wraps to 0x0000.
- cen=0: all registers and outputs hold. Strobes stay asserted, so the bus must qualify them with cen.
- rst mid-transfer: return to IDLE at once. No done, no sp_we; bytes already written remain.
- we and re are never both 1.

Decomposition:
- jtkcpu_pkg holds the register codes REG_CC=0, REG_A=1, REG_B=2, REG_DP=3, REG_X=4, REG_Y=5, REG_US=6, REG_PC=7, plus an is16(code) function (code>=4).
- Sub-module jtkcpu_pshpul_pick: a combinational priority picker that returns the next set mask bit, highest-first for push and lowest-first for pull.

Test Plan:
- Push PC,B,A: psh_go, postbyte=0x86, sp_in=0x1000 -> writes PCL@0x0FFF, PCH@0x0FFE, B@0x0FFD, A@0x0FFC over 4 cen cycles; done with sp_out=0x0FFC.
- Pull all: pul_go, postbyte=0xFF, sp_in=0x0FF4 -> reads CC@0x0FF4, A, B, DP, XH, XL, YH, YL, UH, UL, PCH, PCL@0x0FFF; 12 ld_we pulses with matching ld_sel/ld_hi; sp_out=0x1000.
- Empty mask: psh_go, postbyte=0x00, sp_in=0x2000 -> no we/re; done and sp_we one cen cycle later; sp_out=0x2000.
- Wrap: push A, postbyte=0x02, sp_in=0x0000 -> write @0xFFFF; sp_out=0xFFFF. Pull CC from sp_in=0xFFFF -> sp_out=0x0000.
- Stall/priority: toggle cen 1/0 during push 0x30 -> byte sequence identical, held while cen=0. psh_go and pul_go together -> push performed. psh_go while busy -> ignored.
- Reset mid-op: assert rst after 2 bytes of push 0xF0 -> next cycle busy=0, we=0, no done/sp_we; a new push afterwards runs normally.
